encoder_frame_serializer: RTL and testbench

//  Downstream of the encoder counter generator. Consumes its bit clock and bit/channel/frame counters.

---
 rtl/encoder_pkg.sv | 27 ++
 rtl/encoder_payload_fetch.sv | 121 ++++++++++++
 rtl/encoder_frame_serializer.sv | 126 ++++++++++++
 tb/tb_encoder_frame_serializer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// Shared definitions for the encoder frame path.
// Holds the counter field widths, the fixed header channel numbers and the
// state type of the payload fetch FSM. Imported by the serializer top and its
// payload fetch sub-module.
package encoder_pkg;

    localparam int CH_W    = 7;
    localparam int BIT_W   = 3;
    localparam int FRAME_W = 16;
    localparam int BYTE_W  = 8;

    // Header channels carrying the sync word and the frame number
    localparam logic [CH_W-1:0] CH_SYNC_HI  = 7'd0;
    localparam logic [CH_W-1:0] CH_SYNC_LO  = 7'd1;
    localparam logic [CH_W-1:0] CH_FRAME_HI = 7'd2;
    localparam logic [CH_W-1:0] CH_FRAME_LO = 7'd3;

    // Last channel of a frame; its boundary is where the next frame begins
    localparam logic [CH_W-1:0] CH_LAST     = 7'd127;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_REQ,
        FETCH_HELD
    } fetch_state_e;

endpackage

// File: rtl/encoder_payload_fetch.sv
// Payload fetch engine for the frame serializer.
// Opens one request per payload channel at the channel-start cycle of the
// preceding channel and closes it by that channel's boundary cycle at the
// latest. A byte that arrives in time is held (or bypassed straight through on
// the boundary cycle); a missed deadline yields the fill byte and bumps a
// saturating underrun counter.
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   chan_start      channel-start decode (first clock of bit 0)
//   chan_boundary   channel-boundary decode (last clock of bit 7)
//   next_ch         channel that will be loaded at the coming boundary
//   data_in         payload byte from the data source
//   data_valid      data_in valid, honoured only while a request is open
//   data_req        request open towards the data source
//   data_addr       channel being requested, stable while data_req is high
//   payload_byte    byte the serializer should load for a payload channel
//   underrun_count  saturating count of fill-byte substitutions
module encoder_payload_fetch
    import encoder_pkg::*;
#(
    parameter logic [BYTE_W-1:0] FILL_BYTE        = 8'h55,
    parameter logic [CH_W-1:0]   FIRST_PAYLOAD_CH = 7'd4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              chan_start,
    input  logic              chan_boundary,
    input  logic [CH_W-1:0]   next_ch,
    input  logic [BYTE_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_req,
    output logic [CH_W-1:0]   data_addr,
    output logic [BYTE_W-1:0] payload_byte,
    output logic [BYTE_W-1:0] underrun_count
);

    fetch_state_e      state_q, state_d;
    logic [BYTE_W-1:0] hold_q, hold_d;
    logic              filled_q, filled_d;
    logic [CH_W-1:0]   addr_q, addr_d;
    logic [BYTE_W-1:0] underrun_q, underrun_d;
    logic              accept;

    // State and datapath registers; reset leaves the engine idle with no
    // request open and an empty holding register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FETCH_IDLE;
            hold_q     <= '0;
            filled_q   <= 1'b0;
            addr_q     <= '0;
            underrun_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            filled_q   <= filled_d;
            addr_q     <= addr_d;
            underrun_q <= underrun_d;
        end
    end

    // Next-state logic. Only the start/boundary decodes move the FSM, so a
    // jump in the upstream counters can at worst leave a request open until
    // the next boundary, which always closes it.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        filled_d   = filled_q;
        addr_d     = addr_q;
        underrun_d = underrun_q;
        accept     = (state_q == FETCH_REQ) && data_valid;

        case (state_q)
            FETCH_IDLE: begin
                if (chan_start && (next_ch >= FIRST_PAYLOAD_CH)) begin
                    state_d  = FETCH_REQ;
                    addr_d   = next_ch;
                    filled_d = 1'b0;
                end
            end
            FETCH_REQ: begin
                if (data_valid) begin
                    hold_d   = data_in;
                    filled_d = 1'b1;
                    // A byte landing on the boundary is consumed right away
                    state_d  = chan_boundary ? FETCH_IDLE : FETCH_HELD;
                end else if (chan_boundary) begin
                    state_d = FETCH_IDLE;
                    if (underrun_q != 8'hFF) begin
                        underrun_d = underrun_q + 8'd1;
                    end
                end
            end
            FETCH_HELD: begin
                if (chan_boundary) begin
                    state_d = FETCH_IDLE;
                end
            end
            default: begin
                state_d = FETCH_IDLE;
            end
        endcase
    end

    // The live data_in is forwarded when it is accepted on the boundary cycle
    // itself, otherwise the held byte or the fill byte.
    always_comb begin
        if (accept) begin
            payload_byte = data_in;
        end else if (filled_q) begin
            payload_byte = hold_q;
        end else begin
            payload_byte = FILL_BYTE;
        end
    end

    assign data_req       = (state_q == FETCH_REQ);
    assign data_addr      = addr_q;
    assign underrun_count = underrun_q;

endmodule

// File: rtl/encoder_frame_serializer.sv
// Frame serializer downstream of the encoder counter generator.
// Builds a 128-channel x 8-bit frame sent MSB first: sync word in ch0/ch1,
// frame number in ch2/ch3, payload in the remaining channels fetched through
// encoder_payload_fetch. Serial_Out trails the counters by one clock.
// Ports:
//   CLOCK_BMQ        system clock shared with the counter generator
//   RESET            asynchronous active-high reset
//   CLOCK_Bit        bit-phase flag, one bit lasts two clocks
//   Counter_Bits     bit index within the channel
//   Counter_Channel  channel index 0..127
//   Counter_Frame    frame number
//   Data_Req         payload request
//   Data_Addr        channel being requested
//   Data_In          payload byte
//   Data_Valid       Data_In valid while Data_Req is high
//   Serial_Out       serial bit stream
//   Frame_Sync       high while the first bit of ch0 is on Serial_Out
//   Underrun_Count   saturating count of fill-byte substitutions
module encoder_frame_serializer
    import encoder_pkg::*;
#(
    parameter logic [2*BYTE_W-1:0] SYNC_WORD        = 16'hEB90,
    parameter logic [BYTE_W-1:0]   FILL_BYTE        = 8'h55,
    parameter logic [CH_W-1:0]     FIRST_PAYLOAD_CH = 7'd4
) (
    input  logic               CLOCK_BMQ,
    input  logic               RESET,
    input  logic               CLOCK_Bit,
    input  logic [BIT_W-1:0]   Counter_Bits,
    input  logic [CH_W-1:0]    Counter_Channel,
    input  logic [FRAME_W-1:0] Counter_Frame,
    output logic               Data_Req,
    output logic [CH_W-1:0]    Data_Addr,
    input  logic [BYTE_W-1:0]  Data_In,
    input  logic               Data_Valid,
    output logic               Serial_Out,
    output logic               Frame_Sync,
    output logic [BYTE_W-1:0]  Underrun_Count
);

    logic               chan_start;
    logic               chan_boundary;
    logic [CH_W-1:0]    next_ch;
    logic [BYTE_W-1:0]  payload_byte;
    logic [BYTE_W-1:0]  next_byte;

    logic [BYTE_W-1:0]  shreg_q, shreg_d;
    logic               serial_q, serial_d;
    logic               frame_sync_q, frame_sync_d;
    logic [FRAME_W-1:0] frame_latch_q, frame_latch_d;

    // Counter decodes; next_ch wraps 127 -> 0 through the 7-bit add
    assign chan_start    = (Counter_Bits == 3'd0) && !CLOCK_Bit;
    assign chan_boundary = (Counter_Bits == 3'd7) && CLOCK_Bit;
    assign next_ch       = Counter_Channel + 7'd1;

    encoder_payload_fetch #(
        .FILL_BYTE        (FILL_BYTE),
        .FIRST_PAYLOAD_CH (FIRST_PAYLOAD_CH)
    ) u_fetch (
        .clk            (CLOCK_BMQ),
        .rst            (RESET),
        .chan_start     (chan_start),
        .chan_boundary  (chan_boundary),
        .next_ch        (next_ch),
        .data_in        (Data_In),
        .data_valid     (Data_Valid),
        .data_req       (Data_Req),
        .data_addr      (Data_Addr),
        .payload_byte   (payload_byte),
        .underrun_count (Underrun_Count)
    );

    // Byte for the channel about to start. Channels between the frame number
    // and the first fetched channel carry fill without counting an underrun.
    always_comb begin
        case (next_ch)
            CH_SYNC_HI:  next_byte = SYNC_WORD[15:8];
            CH_SYNC_LO:  next_byte = SYNC_WORD[7:0];
            CH_FRAME_HI: next_byte = frame_latch_q[15:8];
            CH_FRAME_LO: next_byte = frame_latch_q[7:0];
            default:     next_byte = (next_ch >= FIRST_PAYLOAD_CH) ? payload_byte : FILL_BYTE;
        endcase
    end

    // Serializer and header datapath. The frame latch is loaded at the last
    // boundary of a frame with the number of the frame about to begin, so
    // both frame-number bytes always describe the frame they are sent in.
    // Frame_Sync is decoded one clock early so that, once registered, it
    // lines up with the first sync bit on Serial_Out.
    always_comb begin
        shreg_d       = shreg_q;
        frame_latch_d = frame_latch_q;
        serial_d      = shreg_q[7];
        frame_sync_d  = (Counter_Channel == CH_SYNC_HI) && (Counter_Bits == 3'd0);

        if (chan_boundary) begin
            shreg_d = next_byte;
        end else if (CLOCK_Bit) begin
            shreg_d = {shreg_q[6:0], 1'b0};
        end

        if (chan_boundary && (Counter_Channel == CH_LAST)) begin
            frame_latch_d = Counter_Frame + 16'd1;
        end
    end

    // Output and datapath registers; reset forces all outputs low at once
    always_ff @(posedge CLOCK_BMQ or posedge RESET) begin
        if (RESET) begin
            shreg_q       <= '0;
            serial_q      <= 1'b0;
            frame_sync_q  <= 1'b0;
            frame_latch_q <= '0;
        end else begin
            shreg_q       <= shreg_d;
            serial_q      <= serial_d;
            frame_sync_q  <= frame_sync_d;
            frame_latch_q <= frame_latch_d;
        end
    end

    assign Serial_Out = serial_q;
    assign Frame_Sync = frame_sync_q;

endmodule

// File: tb/tb_encoder_frame_serializer.sv
// Self-checking bench for encoder_frame_serializer.
// The counters come from a 27-bit free-running model sliced like the counter
// generator: [0] bit phase, [3:1] bit, [10:4] channel, [26:11] frame.
// A data source model answers requests in one of three ways, and the serial
// stream is deserialized back into one byte per channel for checking.
module tb_encoder_frame_serializer;

    logic        CLOCK_BMQ;
    logic        RESET;
    logic        CLOCK_Bit;
    logic [2:0]  Counter_Bits;
    logic [6:0]  Counter_Channel;
    logic [15:0] Counter_Frame;
    logic        Data_Req;
    logic [6:0]  Data_Addr;
    logic [7:0]  Data_In;
    logic        Data_Valid;
    logic        Serial_Out;
    logic        Frame_Sync;
    logic [7:0]  Underrun_Count;

    // Data source behaviour: 0 answers on the 4th request clock, 1 never
    // answers, 2 answers only on the boundary cycle and drives stray valid
    // pulses whenever no request is open.
    localparam int SRC_DELAYED = 0;
    localparam int SRC_SILENT  = 1;
    localparam int SRC_AT_B    = 2;

    typedef struct {
        int          mode;
        logic [15:0] frame;
        logic [31:0] hdr;
        logic [6:0]  ch_a;
        logic [7:0]  exp_a;
        logic [6:0]  ch_b;
        logic [7:0]  exp_b;
        logic [7:0]  exp_under;
    } vec_t;

    vec_t        vecs [4];
    logic [26:0] cnt;
    int          mode;
    int          req_age;
    logic        req_prev;
    logic [7:0]  acc;
    logic [7:0]  rx_byte [0:127];
    int          req_cnt [0:127];
    int          fs_high;
    int          fs_bad;
    int          assertions;
    int          failures;

    encoder_frame_serializer dut (
        .CLOCK_BMQ       (CLOCK_BMQ),
        .RESET           (RESET),
        .CLOCK_Bit       (CLOCK_Bit),
        .Counter_Bits    (Counter_Bits),
        .Counter_Channel (Counter_Channel),
        .Counter_Frame   (Counter_Frame),
        .Data_Req        (Data_Req),
        .Data_Addr       (Data_Addr),
        .Data_In         (Data_In),
        .Data_Valid      (Data_Valid),
        .Serial_Out      (Serial_Out),
        .Frame_Sync      (Frame_Sync),
        .Underrun_Count  (Underrun_Count)
    );

    // Free-running system clock, 10 time units per period
    initial CLOCK_BMQ = 1'b0;
    always #5 CLOCK_BMQ = ~CLOCK_BMQ;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic clearStats();
        for (int c = 0; c < 128; c++) begin
            rx_byte[c] = 8'hxx;
            req_cnt[c] = 0;
        end
        fs_high  = 0;
        fs_bad   = 0;
        req_prev = Data_Req;
    endtask

    // Advance n clocks: step the counter model, drive the data source, then
    // observe the DUT outputs produced by the edge just taken.
    task automatic applyStimulus(input int n);
        logic is_b;
        logic fs_exp;
        for (int i = 0; i < n; i++) begin
            @(posedge CLOCK_BMQ);
            #1;
            cnt             = cnt + 27'd1;
            CLOCK_Bit       = cnt[0];
            Counter_Bits    = cnt[3:1];
            Counter_Channel = cnt[10:4];
            Counter_Frame   = cnt[26:11];

            if (Data_Req) req_age++;
            else          req_age = 0;
            is_b       = (cnt[3:1] == 3'd7) && cnt[0];
            Data_Valid = 1'b0;
            Data_In    = 8'h00;
            case (mode)
                SRC_DELAYED: begin
                    if (Data_Req && req_age == 4) begin
                        Data_Valid = 1'b1;
                        Data_In    = 8'(32'(Data_Addr) * 3);
                    end
                end
                SRC_AT_B: begin
                    if (Data_Req) begin
                        if (is_b) begin
                            Data_Valid = 1'b1;
                            Data_In    = 8'(32'(Data_Addr) * 3);
                        end
                    end else begin
                        Data_Valid = 1'b1;
                        Data_In    = 8'hEE;
                    end
                end
                default: ;
            endcase

            if (Data_Req && !req_prev) req_cnt[Data_Addr]++;
            req_prev = Data_Req;

            if (CLOCK_Bit) begin
                acc = {acc[6:0], Serial_Out};
                if (Counter_Bits == 3'd7) rx_byte[Counter_Channel] = acc;
            end

            fs_exp = (Counter_Channel == 7'd0) &&
                     ((Counter_Bits == 3'd0 && CLOCK_Bit) || (Counter_Bits == 3'd1 && !CLOCK_Bit));
            if (Frame_Sync) fs_high++;
            if (Frame_Sync !== fs_exp) fs_bad++;
        end
    endtask

    // Hold reset for a few clocks, then release it in the cycle that shows
    // counter value 'start', so the first edge after release acts on it.
    task automatic resetTo(input logic [26:0] start);
        RESET = 1'b1;
        applyStimulus(2);
        cnt = start - 27'd1;
        applyStimulus(1);
        RESET = 1'b0;
        clearStats();
    endtask

    initial begin
        int          errs;
        logic [15:0] prev_frame;
        logic [7:0]  exp_byte;

        assertions      = 0;
        failures        = 0;
        RESET           = 1'b1;
        cnt             = '0;
        mode            = SRC_DELAYED;
        req_age         = 0;
        req_prev        = 1'b0;
        acc             = '0;
        CLOCK_Bit       = 1'b0;
        Counter_Bits    = '0;
        Counter_Channel = '0;
        Counter_Frame   = '0;
        Data_In         = '0;
        Data_Valid      = 1'b0;

        vecs[0] = '{mode: SRC_DELAYED, frame: 16'h1234, hdr: 32'hEB901234,
                    ch_a: 7'd4, exp_a: 8'h0C, ch_b: 7'd127, exp_b: 8'h7D, exp_under: 8'd0};
        vecs[1] = '{mode: SRC_DELAYED, frame: 16'h0000, hdr: 32'hEB900000,
                    ch_a: 7'd5, exp_a: 8'h0F, ch_b: 7'd100, exp_b: 8'h2C, exp_under: 8'd0};
        vecs[2] = '{mode: SRC_SILENT,  frame: 16'h0042, hdr: 32'hEB900042,
                    ch_a: 7'd4, exp_a: 8'h55, ch_b: 7'd127, exp_b: 8'h55, exp_under: 8'd124};
        vecs[3] = '{mode: SRC_AT_B,    frame: 16'hABCD, hdr: 32'hEB90ABCD,
                    ch_a: 7'd4, exp_a: 8'h0C, ch_b: 7'd85,  exp_b: 8'hFF, exp_under: 8'd0};

        #1;
        checkOutput("reset Data_Req", 32'(Data_Req), 32'd0);
        checkOutput("reset Data_Addr", 32'(Data_Addr), 32'd0);
        checkOutput("reset Serial_Out", 32'(Serial_Out), 32'd0);
        checkOutput("reset Frame_Sync", 32'(Frame_Sync), 32'd0);
        checkOutput("reset Underrun_Count", 32'(Underrun_Count), 32'd0);

        // Whole-frame vectors: start in ch127 of the previous frame so the
        // frame latch is loaded, then capture one complete frame.
        for (int v = 0; v < 4; v++) begin
            mode       = vecs[v].mode;
            prev_frame = vecs[v].frame - 16'd1;
            resetTo({prev_frame, 7'd127, 4'd0});
            applyStimulus(2063);
            for (int k = 0; k < 4; k++) begin
                checkOutput($sformatf("v%0d header ch%0d", v, k), 32'(rx_byte[k]),
                            32'(vecs[v].hdr[31-8*k -: 8]));
            end
            checkOutput($sformatf("v%0d ch%0d", v, vecs[v].ch_a), 32'(rx_byte[vecs[v].ch_a]), 32'(vecs[v].exp_a));
            checkOutput($sformatf("v%0d ch%0d", v, vecs[v].ch_b), 32'(rx_byte[vecs[v].ch_b]), 32'(vecs[v].exp_b));
            checkOutput($sformatf("v%0d underrun", v), 32'(Underrun_Count), 32'(vecs[v].exp_under));
            errs = 0;
            for (int c = 4; c < 128; c++) begin
                exp_byte = (vecs[v].mode == SRC_SILENT) ? 8'h55 : 8'(c * 3);
                if (rx_byte[c] !== exp_byte) errs++;
            end
            checkOutput($sformatf("v%0d payload channels wrong", v), 32'(errs), 32'd0);
            errs = 0;
            for (int c = 0; c < 128; c++) begin
                if (req_cnt[c] != ((c >= 4) ? 1 : 0)) errs++;
            end
            checkOutput($sformatf("v%0d request count errors", v), 32'(errs), 32'd0);
            checkOutput($sformatf("v%0d Frame_Sync high clocks", v), 32'(fs_high), 32'd2);
            checkOutput($sformatf("v%0d Frame_Sync misplaced", v), 32'(fs_bad), 32'd0);
        end

        // Underrun counter saturation with a silent data source
        mode = SRC_SILENT;
        resetTo(27'd0);
        applyStimulus(2047);
        checkOutput("underrun after 1 frame", 32'(Underrun_Count), 32'd124);
        applyStimulus(2048);
        checkOutput("underrun after 2 frames", 32'(Underrun_Count), 32'd248);
        applyStimulus(2048);
        checkOutput("underrun after 3 frames", 32'(Underrun_Count), 32'd255);
        applyStimulus(2048);
        checkOutput("underrun holds at 255", 32'(Underrun_Count), 32'd255);

        // Reset mid-channel with a request open: outputs drop before any edge
        mode = SRC_SILENT;
        resetTo({16'd7, 7'd3, 4'd0});
        applyStimulus(119);
        checkOutput("pre-reset Data_Req", 32'(Data_Req), 32'd1);
        checkOutput("pre-reset Data_Addr", 32'(Data_Addr), 32'd11);
        checkOutput("pre-reset Underrun_Count", 32'(Underrun_Count), 32'd7);
        checkOutput("pre-reset Serial_Out", 32'(Serial_Out), 32'd1);
        #3;
        RESET = 1'b1;
        #1;
        checkOutput("async reset Data_Req", 32'(Data_Req), 32'd0);
        checkOutput("async reset Data_Addr", 32'(Data_Addr), 32'd0);
        checkOutput("async reset Serial_Out", 32'(Serial_Out), 32'd0);
        checkOutput("async reset Underrun_Count", 32'(Underrun_Count), 32'd0);
        mode = SRC_DELAYED;
        applyStimulus(3);
        RESET = 1'b0;
        clearStats();
        applyStimulus(37);
        checkOutput("post-reset ch12", 32'(rx_byte[12]), 32'h24);
        checkOutput("post-reset ch12 requests", 32'(req_cnt[12]), 32'd1);
        checkOutput("post-reset underrun", 32'(Underrun_Count), 32'd0);

        // Counter jump from ch10 to ch100 with a request open
        mode = SRC_SILENT;
        resetTo({16'd3, 7'd10, 4'd0});
        applyStimulus(5);
        checkOutput("pre-jump Data_Req", 32'(Data_Req), 32'd1);
        checkOutput("pre-jump Data_Addr", 32'(Data_Addr), 32'd11);
        cnt = {16'd3, 7'd100, 4'd4} - 27'd1;
        applyStimulus(13);
        checkOutput("post-jump request closed", 32'(Data_Req), 32'd0);
        checkOutput("post-jump underrun", 32'(Underrun_Count), 32'd1);
        mode = SRC_DELAYED;
        applyStimulus(31);
        checkOutput("post-jump ch102", 32'(rx_byte[102]), 32'h32);
        applyStimulus(1);
        checkOutput("post-jump no stuck request", 32'(Data_Req), 32'd0);
        checkOutput("post-jump underrun stable", 32'(Underrun_Count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
